// File: rtl/adder_result_display.sv
// adder_result_display
//
// Captures each {cout,sum} result from the parallel adder through a
// valid/ready handshake, blinks it on a 7-segment digit (BLANK/SHOW pairs,
// each phase MAX_COUNT cycles, N_BLINK pairs), then holds the digit lit
// until the next result arrives. The decimal point carries the held carry.
//
// Handshake: a result is accepted on a rising edge where in_valid and
// in_ready are both 1. Upstream keeps in_valid and the data stable until
// then. in_ready is only high in IDLE and never during or on the first
// edge out of reset, so in_valid/data while in_ready=0 are ignored.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   upstream result valid
//   in_ready   out  ready to accept (IDLE and out of reset)
//   sum[2:0]   in   adder sum
//   cout       in   adder carry-out
//   seg[6:0]   out  {g,f,e,d,c,b,a}, active high
//   dp         out  decimal point = held carry while lit
//   busy       out  high in BLANK and SHOW
//   done       out  one-cycle pulse after SHOW->IDLE
//   dbg_state  out  current FSM state, for observation only
//
// All outputs decode from registers only; no input reaches an output
// combinationally.

module adder_result_display #(
  parameter int MAX_COUNT = 1000,
  parameter int N_BLINK   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] sum,
  input  logic       cout,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int DW = $clog2(MAX_COUNT + 1);
  localparam int BW = (N_BLINK > 1) ? $clog2(N_BLINK) : 1;

  localparam logic [DW-1:0] DCNT_LAST = DW'(MAX_COUNT - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(N_BLINK - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [3:0]      val_q,      val_d;
  logic            have_val_q, have_val_d;
  logic [DW-1:0]   dcnt_q,     dcnt_d;
  logic [BW-1:0]   bcnt_q,     bcnt_d;
  logic            done_q,     done_d;
  // Goes high on the first edge with rst=0; keeps in_ready low during reset
  // without a combinational path from rst to in_ready.
  logic            live_q,     live_d;

  logic            accept;
  logic            lit;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign in_ready = live_q && (state_q == ST_IDLE);
  // in_ready is registered-state only, so X on in_valid while not ready
  // still yields accept=0 and never touches val.
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    have_val_d = have_val_q;
    dcnt_d     = dcnt_q;
    bcnt_d     = bcnt_q;
    done_d     = 1'b0;
    live_d     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_BLANK;
          val_d      = {cout, sum};
          have_val_d = 1'b1;
          dcnt_d     = '0;
          bcnt_d     = '0;
        end
      end

      ST_BLANK: begin
        if (dcnt_q == DCNT_LAST) begin
          dcnt_d  = '0;
          state_d = ST_SHOW;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      ST_SHOW: begin
        if (dcnt_q == DCNT_LAST) begin
          dcnt_d = '0;
          if (bcnt_q == BCNT_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bcnt_d  = bcnt_q + BW'(1);
            state_d = ST_BLANK;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      val_q      <= 4'h0;
      have_val_q <= 1'b0;
      dcnt_q     <= '0;
      bcnt_q     <= '0;
      done_q     <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      have_val_q <= have_val_d;
      dcnt_q     <= dcnt_d;
      bcnt_q     <= bcnt_d;
      done_q     <= done_d;
      live_q     <= live_d;
    end
  end

  // Digit is lit in SHOW and while holding a captured value in IDLE.
  assign lit       = (state_q == ST_SHOW) || ((state_q == ST_IDLE) && have_val_q);
  assign seg       = lit ? hex7(val_q) : 7'h00;
  assign dp        = lit ? val_q[3] : 1'b0;
  assign busy      = (state_q == ST_BLANK) || (state_q == ST_SHOW);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_result_display.sv
module tb_adder_result_display;

  localparam int M0 = 4;
  localparam int N0 = 2;
  localparam int B0 = 2 * M0 * N0;
  localparam int M1 = 1;
  localparam int N1 = 1;
  localparam int B1 = 2 * M1 * N1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: MAX_COUNT=4, N_BLINK=2
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] sum = 3'd0;
  logic       cout = 1'b0;
  logic [6:0] seg;
  logic       dp, busy, done;
  logic [1:0] dbg_state;

  // DUT1: MAX_COUNT=1, N_BLINK=1
  logic       rst1 = 1'b1;
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [2:0] sum1 = 3'd0;
  logic       cout1 = 1'b0;
  logic [6:0] seg1;
  logic       dp1, busy1, done1;
  logic [1:0] dbg_state1;

  adder_result_display #(.MAX_COUNT(M0), .N_BLINK(N0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .seg(seg), .dp(dp), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  adder_result_display #(.MAX_COUNT(M1), .N_BLINK(N1)) u_dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sum(sum1), .cout(cout1), .seg(seg1), .dp(dp1), .busy(busy1), .done(done1),
    .dbg_state(dbg_state1)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: values the bench expects to see held when done pulses.
  logic [3:0] exp_q[$];

  // ---------------- reference model ----------------
  // Each DUT is described by: out of reset yet, holding a value, the value,
  // and j = cycles since the accepting edge (-1 = nothing accepted).
  bit         m0_live = 1'b0, m0_have = 1'b0;
  logic [3:0] m0_v = 4'h0;
  int         m0_j = -1;
  bit         m1_live = 1'b0, m1_have = 1'b0;
  logic [3:0] m1_v = 4'h0;
  int         m1_j = -1;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Expected {in_ready, done, busy, dp, seg} after the current edge.
  function automatic logic [10:0] model_out(input bit live, input bit have,
                                            input logic [3:0] v, input int j,
                                            input int m, input int n);
    int   busy_len;
    logic lit, rdy, dn, bz;
    busy_len = 2 * m * n;
    if (!live) return 11'h000;
    if (j >= 0 && j < busy_len) begin
      bz = 1'b1; rdy = 1'b0; dn = 1'b0;
      lit = ((j / m) % 2) == 1;
    end else begin
      bz = 1'b0; rdy = 1'b1;
      dn = (j == busy_len);
      lit = have;
    end
    return {rdy, dn, bz, (lit ? v[3] : 1'b0), (lit ? hex7(v) : 7'h00)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step0();
    bit rdy;
    rdy = m0_live && (m0_j < 0 || m0_j >= B0);
    @(posedge clk);
    if (rst) begin
      m0_live = 1'b0; m0_have = 1'b0; m0_j = -1;
      exp_q.delete();
    end else begin
      m0_live = 1'b1;
      if (in_valid && rdy) begin
        m0_j = 0; m0_v = {cout, sum}; m0_have = 1'b1;
        exp_q.push_back({cout, sum});
      end else if (m0_j >= 0) begin
        m0_j++;
      end
    end
    #1;
  endtask

  task automatic step1();
    bit rdy;
    rdy = m1_live && (m1_j < 0 || m1_j >= B1);
    @(posedge clk);
    if (rst1) begin
      m1_live = 1'b0; m1_have = 1'b0; m1_j = -1;
    end else begin
      m1_live = 1'b1;
      if (in_valid1 && rdy) begin
        m1_j = 0; m1_v = {cout1, sum1}; m1_have = 1'b1;
      end else if (m1_j >= 0) begin
        m1_j++;
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [10:0] obs, exp_o;
    rst = 1'b1; in_valid = 1'b1; sum = 3'd5; cout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step0();
      obs = {in_ready, done, busy, dp, seg};
      checks++;
      if (obs !== 11'h000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, 11'h000);
      end
    end
    // Release with in_valid still high: in_ready was 0, so nothing captured.
    rst = 1'b0;
    step0();
    obs = {in_ready, done, busy, dp, seg};
    exp_o = model_out(m0_live, m0_have, m0_v, m0_j, M0, N0);
    checks++;
    if (obs !== exp_o || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", obs, exp_o);
    end
    in_valid = 1'b0;
    step0();
    obs = {in_ready, done, busy, dp, seg};
    exp_o = model_out(m0_live, m0_have, m0_v, m0_j, M0, N0);
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=%h", obs, exp_o);
    end
  endtask

  task automatic test_basic();
    logic [10:0] obs, exp_o;
    logic [3:0]  e;
    int          n_done;
    n_done = 0;
    sum = 3'd3; cout = 1'b0; in_valid = 1'b1;
    step0();
    in_valid = 1'b0;
    for (int c = 0; c < B0 + 4; c++) begin
      obs = {in_ready, done, busy, dp, seg};
      exp_o = model_out(m0_live, m0_have, m0_v, m0_j, M0, N0);
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL basic j=%0d got=%h exp=%h", m0_j, obs, exp_o);
      end
      if (done === 1'b1) begin
        n_done++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL basic_sb unexpected done got=%h exp=none", seg);
        end else begin
          e = exp_q.pop_front();
          if (seg !== hex7(e)) begin
            errors++;
            $display("FAIL basic_sb got=%h exp=%h", seg, hex7(e));
          end
        end
      end
      sum = 3'($urandom_range(0, 7)); cout = 1'($urandom_range(0, 1));
      step0();
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL basic_done_count got=%0d exp=1", n_done);
    end
  endtask

  task automatic test_carry();
    logic [10:0] obs, exp_o;
    sum = 3'd7; cout = 1'b1; in_valid = 1'b1;
    step0();
    in_valid = 1'b0;
    sum = 3'bxxx; cout = 1'bx;
    for (int c = 0; c < B0 + 3; c++) begin
      obs = {in_ready, done, busy, dp, seg};
      exp_o = model_out(m0_live, m0_have, m0_v, m0_j, M0, N0);
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL carry j=%0d got=%h exp=%h", m0_j, obs, exp_o);
      end
      step0();
    end
    exp_q.delete();
    sum = 3'd0; cout = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [10:0] obs, exp_o;
    logic [3:0]  e;
    exp_q.delete();
    sum = 3'd1; cout = 1'b0; in_valid = 1'b1;
    step0();
    in_valid = 1'b0;
    for (int c = 0; c < 2 * B0 + 4; c++) begin
      obs = {in_ready, done, busy, dp, seg};
      exp_o = model_out(m0_live, m0_have, m0_v, m0_j, M0, N0);
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL backpressure c=%0d j=%0d got=%h exp=%h", c, m0_j, obs, exp_o);
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL backpressure_sb unexpected done got=%h exp=none", seg);
        end else begin
          e = exp_q.pop_front();
          if (seg !== hex7(e)) begin
            errors++;
            $display("FAIL backpressure_sb got=%h exp=%h", seg, hex7(e));
          end
        end
      end
      if (c == 5) begin
        in_valid = 1'b1; sum = 3'd2; cout = 1'b0;
      end
      step0();
      if (c >= 5 && m0_j == 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs, exp_o;
    sum = 3'($urandom_range(0, 7)); cout = 1'($urandom_range(0, 1)); in_valid = 1'b1;
    step0();
    in_valid = 1'b0;
    while (m0_j < 5) step0();
    rst = 1'b1;
    step0();
    obs = {in_ready, done, busy, dp, seg};
    checks++;
    if (obs !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", obs, 11'h000);
    end
    rst = 1'b0;
    for (int c = 0; c < B0 + 4; c++) begin
      step0();
      obs = {in_ready, done, busy, dp, seg};
      exp_o = model_out(m0_live, m0_have, m0_v, m0_j, M0, N0);
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL reset_mid_after c=%0d got=%h exp=%h", c, obs, exp_o);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] obs, exp_o;
    logic [3:0]  e;
    int          gap;
    for (int r = 0; r < 6; r++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        obs = {in_ready, done, busy, dp, seg};
        exp_o = model_out(m0_live, m0_have, m0_v, m0_j, M0, N0);
        checks++;
        if (obs !== exp_o) begin
          errors++;
          $display("FAIL random_gap r=%0d got=%h exp=%h", r, obs, exp_o);
        end
        if (done === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL random_sb unexpected done got=%h exp=none", seg);
          end else begin
            e = exp_q.pop_front();
            if (seg !== hex7(e)) begin
              errors++;
              $display("FAIL random_sb got=%h exp=%h", seg, hex7(e));
            end
          end
        end
        if (g == gap) begin
          in_valid = 1'b1;
          sum = 3'($urandom_range(0, 7)); cout = 1'($urandom_range(0, 1));
        end
        step0();
      end
      in_valid = 1'b0;
      for (int c = 0; c < B0; c++) begin
        obs = {in_ready, done, busy, dp, seg};
        exp_o = model_out(m0_live, m0_have, m0_v, m0_j, M0, N0);
        checks++;
        if (obs !== exp_o) begin
          errors++;
          $display("FAIL random r=%0d j=%0d got=%h exp=%h", r, m0_j, obs, exp_o);
        end
        sum = 3'($urandom_range(0, 7)); cout = 1'($urandom_range(0, 1));
        step0();
      end
    end
  endtask

  task automatic test_max1();
    logic [10:0] obs, exp_o;
    rst1 = 1'b1;
    step1(); step1();
    rst1 = 1'b0;
    step1();
    sum1 = 3'd0; cout1 = 1'b0; in_valid1 = 1'b1;
    step1();
    in_valid1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      obs = {in_ready1, done1, busy1, dp1, seg1};
      exp_o = model_out(m1_live, m1_have, m1_v, m1_j, M1, N1);
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL max1 j=%0d got=%h exp=%h", m1_j, obs, exp_o);
      end
      step1();
    end
    for (int r = 0; r < 4; r++) begin
      in_valid1 = 1'b1;
      sum1 = 3'($urandom_range(0, 7)); cout1 = 1'($urandom_range(0, 1));
      step1();
      in_valid1 = 1'b0;
      for (int c = 0; c <= B1; c++) begin
        obs = {in_ready1, done1, busy1, dp1, seg1};
        exp_o = model_out(m1_live, m1_have, m1_v, m1_j, M1, N1);
        checks++;
        if (obs !== exp_o) begin
          errors++;
          $display("FAIL max1_rand r=%0d j=%0d got=%h exp=%h", r, m1_j, obs, exp_o);
        end
        if (c < B1) step1();
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    #1;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_max1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
